// File: rtl/ycbcr2rgb_block.sv
// Inverse colour stage: converts one latched 8x8 block of Q16.16 Y/Cb/Cr into
// 8-bit R/G/B using CORE_COUNT converter lanes per cycle.
module ycbcr2rgb_block #(
  parameter int OUTPUT_WIDTH       = 8,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int CONST_W            = 16,
  parameter int PIXEL_COUNT        = 64,
  parameter int CORE_COUNT         = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] y_all,
  input  logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cb_all,
  input  logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cr_all,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUTPUT_WIDTH*PIXEL_COUNT-1:0]      r_all,
  output logic [OUTPUT_WIDTH*PIXEL_COUNT-1:0]      g_all,
  output logic [OUTPUT_WIDTH*PIXEL_COUNT-1:0]      b_all
);
  localparam int FW     = FIXED_POINT_LENGTH;
  localparam int OW     = OUTPUT_WIDTH;
  localparam int BEATS  = PIXEL_COUNT / CORE_COUNT;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [CONST_W-1:0] KRCR = 16'sd22970;
  localparam logic signed [CONST_W-1:0] KGCB = 16'sd5638;
  localparam logic signed [CONST_W-1:0] KGCR = 16'sd11700;
  localparam logic signed [CONST_W-1:0] KBCB = 16'sd29032;

  generate
    if ((PIXEL_COUNT % CORE_COUNT) != 0) begin : g_cfg_err
      $error("CORE_COUNT must divide PIXEL_COUNT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_next;
  logic [BEAT_W-1:0]      beat, beat_next;
  logic [FW*PIXEL_COUNT-1:0] y_lat, cb_lat, cr_lat;
  logic [3*OW-1:0]        lane_rgb [CORE_COUNT];

  function automatic logic signed [47:0] sext(input logic [FW-1:0] v);
    return {{(48-FW){v[FW-1]}}, v};
  endfunction

  // Q16.16 times a 14-fractional-bit constant, kept in Q16.16 with full headroom.
  function automatic logic signed [47:0] scale(input logic signed [47:0] d,
                                               input logic signed [CONST_W-1:0] k);
    logic signed [63:0] p;
    p = $signed({{16{d[47]}}, d}) * $signed({{(64-CONST_W){k[CONST_W-1]}}, k});
    p = p >>> 14;
    return p[47:0];
  endfunction

  function automatic logic [OW-1:0] round_clamp(input logic signed [47:0] v);
    logic signed [47:0] t;
    logic [31:0]        i;
    t = v + 48'sh0000_0000_8000;
    i = t[47:16];
    if (i[31]) begin
      return {OW{1'b0}};
    end else if (|i[30:OW]) begin
      return {OW{1'b1}};
    end else begin
      return i[OW-1:0];
    end
  endfunction

  function automatic logic [3*OW-1:0] convert(input logic [FW-1:0] y,
                                              input logic [FW-1:0] cb,
                                              input logic [FW-1:0] cr);
    logic signed [47:0] ys, dcb, dcr, rs, gs, bs;
    ys  = sext(y);
    dcb = sext(cb) - 48'sh0000_0080_0000;
    dcr = sext(cr) - 48'sh0000_0080_0000;
    rs  = ys + scale(dcr, KRCR);
    gs  = ys - scale(dcb, KGCB) - scale(dcr, KGCR);
    bs  = ys + scale(dcb, KBCB);
    return {round_clamp(rs), round_clamp(gs), round_clamp(bs)};
  endfunction

  // Converter lanes for the pixels of the current beat.
  always_comb begin
    for (int l = 0; l < CORE_COUNT; l++) begin
      lane_rgb[l] = convert(y_lat [(int'(beat)*CORE_COUNT + l)*FW +: FW],
                            cb_lat[(int'(beat)*CORE_COUNT + l)*FW +: FW],
                            cr_lat[(int'(beat)*CORE_COUNT + l)*FW +: FW]);
    end
  end

  // Next-state and beat sequencing.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        beat_next = {BEAT_W{1'b0}};
        if (in_valid && in_ready) begin
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      CONV: begin
        beat_next = beat + {{(BEAT_W-1){1'b0}}, 1'b1};
        if (beat == BEAT_W'(BEATS-1)) begin
          state_next = DONE;
        end else begin
          state_next = CONV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State, handshake flags, input latches and output pixel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= {BEAT_W{1'b0}};
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y_lat     <= '0;
      cb_lat    <= '0;
      cr_lat    <= '0;
      r_all     <= '0;
      g_all     <= '0;
      b_all     <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (state == IDLE && in_valid && in_ready) begin
        y_lat  <= y_all;
        cb_lat <= cb_all;
        cr_lat <= cr_all;
      end
      if (state == CONV) begin
        for (int l = 0; l < CORE_COUNT; l++) begin
          r_all[(int'(beat)*CORE_COUNT + l)*OW +: OW] <= lane_rgb[l][3*OW-1 -: OW];
          g_all[(int'(beat)*CORE_COUNT + l)*OW +: OW] <= lane_rgb[l][2*OW-1 -: OW];
          b_all[(int'(beat)*CORE_COUNT + l)*OW +: OW] <= lane_rgb[l][OW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_ycbcr2rgb_block.sv
// Directed scoreboard bench for ycbcr2rgb_block: expected RGB blocks come from a
// real-valued colour model (or the original RGB for round trips).
module tb_ycbcr2rgb_block;
  localparam int PC = 64;
  localparam int FW = 32;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [FW*PC-1:0] y_all = '0, cb_all = '0, cr_all = '0;
  logic [OW*PC-1:0] r_all, g_all, b_all;

  typedef struct {
    logic [OW*PC-1:0] r;
    logic [OW*PC-1:0] g;
    logic [OW*PC-1:0] b;
    int               tol;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ycbcr2rgb_block dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y_all(y_all), .cb_all(cb_all), .cr_all(cr_all),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_all(r_all), .g_all(g_all), .b_all(b_all)
  );

  function automatic logic [7:0] model(real y, real cb, real cr, int ch);
    real dcb, dcr, v;
    dcb = cb - 128.0;
    dcr = cr - 128.0;
    case (ch)
      0:       v = y + 1.402 * dcr;
      1:       v = y - 0.344136 * dcb - 0.714136 * dcr;
      default: v = y + 1.772 * dcb;
    endcase
    v = $floor(v + 0.5);
    if (v < 0.0) return 8'd0;
    if (v > 255.0) return 8'd255;
    return 8'(int'(v));
  endfunction

  function automatic real q2r(logic [31:0] v);
    return $itor($signed(v)) / 65536.0;
  endfunction

  function automatic logic [31:0] r2q(real v);
    return 32'(int'(v * 65536.0));
  endfunction

  task automatic chk8(string tag, int px, logic [7:0] got, logic [7:0] exp, int tol);
    int d;
    d = int'(got) - int'(exp);
    checks++;
    assert ((tol == 0) ? (got === exp) : (!$isunknown(got) && d <= tol && -d <= tol))
    else begin
      errors++;
      $error("FAIL %s px=%0d got=%0d exp=%0d", tag, px, got, exp);
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chkint(string tag, int got, int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chkvec(string tag, logic [OW*PC-1:0] got, logic [OW*PC-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill(logic [31:0] y, logic [31:0] cb, logic [31:0] cr);
    for (int i = 0; i < PC; i++) begin
      y_all[i*FW +: FW]  = y;
      cb_all[i*FW +: FW] = cb;
      cr_all[i*FW +: FW] = cr;
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < PC; i++) begin
      y_all[i*FW +: FW]  = 32'(i) << 16;
      cb_all[i*FW +: FW] = 32'h0080_0000;
      cr_all[i*FW +: FW] = 32'h0080_0000;
    end
  endtask

  // Push the model's expectation for the current inputs (tol<0: caller pushed already).
  task automatic send(int tol);
    exp_t e;
    int   n;
    if (tol >= 0) begin
      for (int i = 0; i < PC; i++) begin
        e.r[i*OW +: OW] = model(q2r(y_all[i*FW +: FW]), q2r(cb_all[i*FW +: FW]), q2r(cr_all[i*FW +: FW]), 0);
        e.g[i*OW +: OW] = model(q2r(y_all[i*FW +: FW]), q2r(cb_all[i*FW +: FW]), q2r(cr_all[i*FW +: FW]), 1);
        e.b[i*OW +: OW] = model(q2r(y_all[i*FW +: FW]), q2r(cb_all[i*FW +: FW]), q2r(cr_all[i*FW +: FW]), 2);
      end
      e.tol = tol;
      sb.push_back(e);
    end
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("send_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("out_valid", out_valid, 1'b1);
  endtask

  task automatic receive(int exp_lat);
    exp_t e;
    int   n;
    wait_valid(n);
    if (exp_lat >= 0) chkint("latency", n, exp_lat);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got=%0d exp=1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < PC; i++) begin
        chk8("r", i, r_all[i*OW +: OW], e.r[i*OW +: OW], e.tol);
        chk8("g", i, g_all[i*OW +: OW], e.g[i*OW +: OW], e.tol);
        chk8("b", i, b_all[i*OW +: OW], e.b[i*OW +: OW], e.tol);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    real  rr, gg, bb;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chkvec("rst_r", r_all, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("ready_after_rst", in_ready, 1'b1);

    // Gray, then both clamp directions.
    fill(32'h0080_0000, 32'h0080_0000, 32'h0080_0000);
    send(0);
    receive(8);
    fill(32'h00FF_0000, 32'h0080_0000, 32'h00FF_0000);
    send(1);
    receive(8);
    fill(32'h0000_0000, 32'h0000_0000, 32'h0080_0000);
    send(1);
    receive(8);

    // Lane/beat ordering: pixel i must come back as i on every channel.
    fill_index();
    send(0);
    receive(8);

    // Backpressure with an ignored in_valid pulse while DONE.
    fill_index();
    send(0);
    wait_valid(n);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        fill(32'h0080_0000, 32'h0000_0000, 32'h0000_0000);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chkvec("hold_r", r_all, sb[0].r);
      chkvec("hold_b", b_all, sb[0].b);
      chk1("hold_in_ready", in_ready, 1'b0);
      chk1("hold_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    receive(-1);
    chk1("idle_ready", in_ready, 1'b1);
    chk1("idle_out_valid", out_valid, 1'b0);

    // Reset at beat 4 discards the partial block.
    fill(32'h00FF_0000, 32'h0080_0000, 32'h00FF_0000);
    send(1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk1("midrst_out_valid", out_valid, 1'b0);
    chkvec("midrst_r", r_all, '0);
    chkvec("midrst_g", g_all, '0);
    chkvec("midrst_b", b_all, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_index();
    send(0);
    receive(8);

    // Round trip through a forward RGB->YCbCr model.
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < PC; i++) begin
        e.r[i*OW +: OW] = 8'($urandom_range(0, 255));
        e.g[i*OW +: OW] = 8'($urandom_range(0, 255));
        e.b[i*OW +: OW] = 8'($urandom_range(0, 255));
        rr = $itor(e.r[i*OW +: OW]);
        gg = $itor(e.g[i*OW +: OW]);
        bb = $itor(e.b[i*OW +: OW]);
        y_all[i*FW +: FW]  = r2q(0.299 * rr + 0.587 * gg + 0.114 * bb);
        cb_all[i*FW +: FW] = r2q(-0.168736 * rr - 0.331264 * gg + 0.5 * bb + 128.0);
        cr_all[i*FW +: FW] = r2q(0.5 * rr - 0.418688 * gg - 0.081312 * bb + 128.0);
      end
      e.tol = 1;
      sb.push_back(e);
      send(-1);
      receive(8);
    end

    chkint("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
